// File: rtl/ram_arbiter.sv
// Two-requester (IF / DM) arbiter and access sequencer for a single-port data RAM.
// Optional `RAM_ARB_RR_EN selects round-robin arbitration; default is fixed DM-over-IF priority.
module ram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              read_ram,
    output logic              write_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              own_dm;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              in_range;
    logic              grant_dm;
    logic              take;

    assign in_range = (lat_addr < ADDR_W'(DEPTH));
    assign take     = (state == IDLE) && (if_req || dm_req);

`ifdef RAM_ARB_RR_EN
    logic prefer_dm;

    assign grant_dm = dm_req && (!if_req || prefer_dm);

    // Pointer favours whichever port was not granted last; DM wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    prefer_dm <= 1'b1;
        else if (take) prefer_dm <= !grant_dm;
    end
`else
    assign grant_dm = dm_req;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            own_dm    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                own_dm    <= grant_dm;
                lat_we    <= grant_dm && dm_we;
                lat_addr  <= grant_dm ? dm_addr : if_addr;
                lat_wdata <= grant_dm ? dm_wdata : '0;
                cnt       <= CNT_W'(WAIT_CYCLES - 1);
            end else if (state == ACCESS) begin
                if (cnt == '0) rdata_q <= (!lat_we && in_range) ? ram_out : '0;
                else           cnt     <= cnt - 1'b1;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt      = state;
        if_gnt         = 1'b0;
        dm_gnt         = 1'b0;
        if_rvalid      = 1'b0;
        if_rdata       = '0;
        if_err         = 1'b0;
        dm_rvalid      = 1'b0;
        dm_rdata       = '0;
        dm_err         = 1'b0;
        read_ram       = 1'b0;
        write_ram      = 1'b0;
        ram_addr       = '0;
        ram_write_data = '0;
        case (state)
            IDLE: begin
                // Gated by rst_n so a request held through reset cannot pulse a grant.
                if (take && rst_n) begin
                    if_gnt    = !grant_dm;
                    dm_gnt    = grant_dm;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_addr       = lat_addr;
                ram_write_data = lat_wdata;
                read_ram       = !lat_we && in_range;
                write_ram      = lat_we && in_range;
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                if (own_dm) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = rdata_q;
                    dm_err    = !in_range;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = rdata_q;
                    if_err    = !in_range;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised bench for ram_arbiter against a transaction-level model of arbitration and RAM contents.
module tb_ram_arbiter;

    localparam int W     = 3;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        read_ram, write_ram, busy;
    logic [31:0] ram_addr, ram_write_data, ram_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    // Pending requests as the requesters see them
    bit          if_p, dm_p, dm_w;
    logic [31:0] if_a, dm_a, dm_d;
    bit          prefer_dm;
    bit          rand_on, hold_both;
    bit          winners[$];

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .read_ram(read_ram), .write_ram(write_ram), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_out(ram_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM behind the arbiter
    assign ram_out = ram_mem[ram_addr[3:0]];
    always @(posedge clk) if (write_ram) ram_mem[ram_addr[3:0]] <= ram_write_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 32'd16 + $urandom_range(0, 15);
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            2:       return $urandom() | 32'h0000_0100;
            default: return 32'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    task automatic drive_inputs();
        if_req   = if_p;
        if_addr  = if_p ? if_a : $urandom();
        dm_req   = dm_p;
        dm_we    = dm_p ? dm_w : 1'($urandom_range(0, 1));
        dm_addr  = dm_p ? dm_a : $urandom();
        dm_wdata = dm_p ? dm_d : $urandom();
    endtask

    task automatic new_if();
        if_p = 1'b1; if_a = rand_addr();
    endtask

    task automatic new_dm();
        dm_p = 1'b1; dm_w = 1'($urandom_range(0, 1)); dm_a = rand_addr(); dm_d = $urandom();
    endtask

    // Requester behaviour while the arbiter is busy: re-arm, raise new requests, or abandon one
    task automatic update_reqs();
        if (hold_both) begin
            if (!if_p) new_if();
            if (!dm_p) new_dm();
        end else if (rand_on) begin
            if (!if_p && $urandom_range(0, 3) == 0) new_if();
            if (!dm_p && $urandom_range(0, 3) == 0) new_dm();
            if (if_p && $urandom_range(0, 9) == 0) if_p = 1'b0;
            if (dm_p && $urandom_range(0, 9) == 0) dm_p = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_inputs();
        #1;
        check("idle_busy", busy, 0);
        check("idle_gnt", {if_gnt, dm_gnt}, 0);
        check("idle_strobe", {read_ram, write_ram}, 0);
    endtask

    // One complete transaction starting in IDLE with at least one request pending
    task automatic run_txn();
        bit          win_dm, we, oor;
        logic [31:0] a, d, exp_data;
        @(negedge clk);
        drive_inputs();
        #1;
        check("gnt_busy", busy, 0);
`ifdef RAM_ARB_RR_EN
        win_dm = dm_p && (!if_p || prefer_dm);
        prefer_dm = !win_dm;
`else
        win_dm = dm_p;
`endif
        check("if_gnt", if_gnt, !win_dm);
        check("dm_gnt", dm_gnt, win_dm);
        winners.push_back(dm_gnt);
        if (win_dm) begin
            a = dm_a; we = dm_w; d = dm_d; dm_p = 1'b0;
        end else begin
            a = if_a; we = 1'b0; d = '0; if_p = 1'b0;
        end
        oor      = (a >= DEPTH);
        exp_data = (!we && !oor) ? ref_mem[a[3:0]] : 32'd0;
        if (we && !oor) ref_mem[a[3:0]] = d;

        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            update_reqs();
            drive_inputs();
            #1;
            check("acc_busy", busy, 1);
            check("acc_gnt", {if_gnt, dm_gnt}, 0);
            check("acc_rvalid", {if_rvalid, dm_rvalid}, 0);
            check("read_ram", read_ram, !we && !oor);
            check("write_ram", write_ram, we && !oor);
            check("ram_addr", ram_addr, a);
            if (win_dm) check("ram_wdata", ram_write_data, d);
        end

        @(negedge clk);
        update_reqs();
        drive_inputs();
        #1;
        check("resp_busy", busy, 1);
        check("resp_gnt", {if_gnt, dm_gnt}, 0);
        check("resp_strobe", {read_ram, write_ram}, 0);
        check("if_rvalid", if_rvalid, !win_dm);
        check("dm_rvalid", dm_rvalid, win_dm);
        check("if_rdata", if_rdata, win_dm ? 32'd0 : exp_data);
        check("dm_rdata", dm_rdata, win_dm ? exp_data : 32'd0);
        check("if_err", if_err, !win_dm && oor);
        check("dm_err", dm_err, win_dm && oor);
    endtask

    initial begin
        rst_n = 1'b0;
        if_p = 0; dm_p = 0; dm_w = 0; if_a = 0; dm_a = 0; dm_d = 0;
        rand_on = 0; hold_both = 0; prefer_dm = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = $urandom();
            ref_mem[i] = ram_mem[i];
        end
        drive_inputs();
        #12;
        check("rst_busy", busy, 0);
        check("rst_outs", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, read_ram, write_ram, if_err, dm_err}, 0);
        check("rst_bus", ram_addr | ram_write_data | if_rdata | dm_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch of word 3
        if_p = 1; if_a = 32'd3;
        run_txn();
        // Store then load back word 5, then an out-of-range load
        dm_p = 1; dm_w = 1; dm_a = 32'd5; dm_d = 32'hDEAD_BEEF;
        run_txn();
        dm_p = 1; dm_w = 0; dm_a = 32'd5;
        run_txn();
        check("ref_5", ref_mem[5], 32'hDEAD_BEEF);
        dm_p = 1; dm_w = 0; dm_a = 32'd16;
        run_txn();

        // Reset during ACCESS drops the transaction
        @(negedge clk);
        if_p = 1; if_a = 32'd3;
        drive_inputs();
        #1;
        check("pre_rst_gnt", if_gnt, 1);
        if_p = 0;
        @(negedge clk);
        drive_inputs();
        #1;
        check("pre_rst_read", read_ram, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_outs", {read_ram, write_ram, if_rvalid, dm_rvalid, if_gnt, dm_gnt}, 0);
        check("mid_rst_addr", ram_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prefer_dm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("post_rst_rvalid", {if_rvalid, dm_rvalid}, 0);
        end

        // Both requesters held for four transactions
        winners.delete();
        hold_both = 1;
        new_if(); new_dm();
        for (int i = 0; i < 4; i++) run_txn();
        hold_both = 0;
`ifdef RAM_ARB_RR_EN
        check("rr_order", {winners[0], winners[1], winners[2], winners[3]}, 4'b1010);
`else
        check("fixed_order", {winners[0], winners[1], winners[2], winners[3]}, 4'b1111);
`endif
        while (if_p || dm_p) run_txn();
        check("if_served_last", winners[winners.size() - 1], 0);

        // Randomised traffic
        rand_on = 1;
        for (int i = 0; i < 300; i++) begin
            if (!if_p && !dm_p) begin
                if ($urandom_range(0, 7) == 0) idle_cycle();
                case ($urandom_range(0, 2))
                    0:       new_if();
                    1:       new_dm();
                    default: begin new_if(); new_dm(); end
                endcase
            end
            run_txn();
        end

        // Whatever the RAM holds must match the model's view
        for (int i = 0; i < DEPTH; i++) check("ram_final", ram_mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
